// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART receiver with 16x oversampling. A two-flop synchronizer
//             cleans up the asynchronous line, the START state qualifies the
//             start bit at mid-bit, and each data bit is sampled 16 ticks
//             later (mid-bit). The stop bit is checked for framing errors.
//  Option   : define UART_RX_PARITY_EN to add one even-parity bit after the
//             data bits. Without it PARITY_ERR is tied to 0.
//  Ports    : CLK        - system clock, rising edge
//             RESET      - synchronous active-high reset
//             TICK       - 16x-baud strobe, one CLK wide
//             RX         - asynchronous serial input, idle high
//             DOUT       - last received word (LSB first on the line)
//             RX_DONE    - one-cycle pulse at the end of each frame
//             FRAME_ERR  - stop bit of the last frame was low
//             PARITY_ERR - parity mismatch in the last frame
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16   // stop length in ticks (16 = 1 bit, 32 = 2 bits)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            TICK,
  input  logic            RX,
  output logic [DBIT-1:0] DOUT,
  output logic            RX_DONE,
  output logic            FRAME_ERR,
  output logic            PARITY_ERR
);

  // A 2-stop-bit configuration needs to count to 31.
  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = 3;

  localparam logic [SW-1:0] C_S_HALF = SW'(7);
  localparam logic [SW-1:0] C_S_BIT  = SW'(15);
  localparam logic [SW-1:0] C_S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] C_N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  // Synchronizer: both flops reset high so reset never fakes a start bit.
  logic            r_rx_meta;
  logic            r_rx_sync;

  state_t          r_state,    w_state_nxt;
  logic [SW-1:0]   r_s,        w_s_nxt;
  logic [NW-1:0]   r_n,        w_n_nxt;
  logic [DBIT-1:0] r_b,        w_b_nxt;
  logic [DBIT-1:0] r_dout,     w_dout_nxt;
  logic            r_done,     w_done_nxt;
  logic            r_ferr,     w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic            r_par,      w_par_nxt;
  logic            r_perr,     w_perr_nxt;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = r_perr;
`endif

    case (r_state)
      ST_IDLE: begin
        // Start detection does not wait for a tick, so the counter phase is
        // anchored to the falling edge itself.
        if (!r_rx_sync) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end

      ST_START: begin
        if (TICK) begin
          if (r_s == C_S_HALF) begin
            if (!r_rx_sync) begin
              w_state_nxt = ST_DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              // Line went high again before mid-bit: treat as a glitch.
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (TICK) begin
          if (r_s == C_S_BIT) begin
            w_s_nxt = '0;
            w_b_nxt = {r_rx_sync, r_b[DBIT-1:1]};
            if (r_n == C_N_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_n_nxt = r_n + NW'(1);
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (TICK) begin
          if (r_s == C_S_BIT) begin
            w_s_nxt     = '0;
            w_par_nxt   = r_rx_sync;
            w_state_nxt = ST_STOP;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        if (TICK) begin
          if (r_s == C_S_STOP) begin
            w_dout_nxt  = r_b;
            w_ferr_nxt  = ~r_rx_sync;
            w_done_nxt  = 1'b1;
            w_s_nxt     = '0;
            w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data ones plus parity bit must be even.
            w_perr_nxt  = (^r_b) ^ r_par;
`endif
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign DOUT      = r_dout;
  assign RX_DONE   = r_done;
  assign FRAME_ERR = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = r_perr;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule
`default_nettype wire
